// File: rtl/zcr_windowed.sv
// zcr_windowed: windowed zero-crossing counter with hysteresis.
// Samples are classified against a symmetric dead band of +/-thresh, a sign
// tracker remembers the last non-dead polarity, and every polarity flip of
// the tracker is counted. After WINDOW_SIZE accepted samples the saturated
// count is published together with a one-cycle valid pulse and a flag that
// tells whether the window ran out of count range.
module zcr_windowed #(
  parameter int DATA_WIDTH  = 16,
  parameter int WINDOW_SIZE = 256,
  parameter int CNT_WIDTH   = 9
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         clear,
  input  logic signed [DATA_WIDTH-1:0] data_in,
  input  logic                         data_valid,
  input  logic        [DATA_WIDTH-2:0] thresh,
  output logic        [CNT_WIDTH-1:0]  zcr_count,
  output logic                         zcr_valid,
  output logic                         zcr_sat
);

  localparam int SCW = (WINDOW_SIZE > 1) ? $clog2(WINDOW_SIZE) : 1;
  localparam logic [SCW-1:0] LAST_IDX = SCW'(WINDOW_SIZE - 1);

  typedef enum logic [1:0] {
    TRK_UNKNOWN = 2'd0,
    TRK_POS     = 2'd1,
    TRK_NEG     = 2'd2
  } trk_t;

  trk_t                   r_trk;
  logic [SCW-1:0]         r_sampleCnt;
  logic [CNT_WIDTH-1:0]   r_acc;
  logic                   r_sticky;
  logic [CNT_WIDTH-1:0]   r_zcrCount;
  logic                   r_zcrValid;
  logic                   r_zcrSat;

  // One extra bit so that -thresh and the most negative sample both fit.
  logic signed [DATA_WIDTH:0] w_dataExt;
  logic signed [DATA_WIDTH:0] w_threshPos;
  logic signed [DATA_WIDTH:0] w_threshNeg;
  logic                       w_accept;
  logic                       w_isPos;
  logic                       w_isNeg;
  logic                       w_crossing;
  logic                       w_accFull;
  logic [CNT_WIDTH-1:0]       w_accNext;
  logic                       w_stickyNext;
  logic                       w_lastSample;

  assign w_dataExt   = {data_in[DATA_WIDTH-1], data_in};
  assign w_threshPos = {2'b00, thresh};
  assign w_threshNeg = -w_threshPos;

  assign w_accept     = enable && data_valid && !clear;
  assign w_isPos      = (w_dataExt > w_threshPos);
  assign w_isNeg      = (w_dataExt < w_threshNeg);
  assign w_crossing   = (w_isPos && (r_trk == TRK_NEG)) ||
                        (w_isNeg && (r_trk == TRK_POS));
  assign w_accFull    = (r_acc == {CNT_WIDTH{1'b1}});
  assign w_accNext    = (w_crossing && !w_accFull) ? (r_acc + 1'b1) : r_acc;
  assign w_stickyNext = r_sticky || (w_crossing && w_accFull);
  assign w_lastSample = (r_sampleCnt == LAST_IDX);

  // Tracker, window bookkeeping and registered outputs in one state machine.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_trk       <= TRK_UNKNOWN;
      r_sampleCnt <= '0;
      r_acc       <= '0;
      r_sticky    <= 1'b0;
      r_zcrCount  <= '0;
      r_zcrValid  <= 1'b0;
      r_zcrSat    <= 1'b0;
    end else begin
      r_zcrValid <= 1'b0;
      if (clear) begin
        r_trk       <= TRK_UNKNOWN;
        r_sampleCnt <= '0;
        r_acc       <= '0;
        r_sticky    <= 1'b0;
      end else if (w_accept) begin
        if (w_isPos) begin
          r_trk <= TRK_POS;
        end else if (w_isNeg) begin
          r_trk <= TRK_NEG;
        end
        if (w_lastSample) begin
          r_zcrCount  <= w_accNext;
          r_zcrSat    <= w_stickyNext;
          r_zcrValid  <= 1'b1;
          r_acc       <= '0;
          r_sticky    <= 1'b0;
          r_sampleCnt <= '0;
        end else begin
          r_acc       <= w_accNext;
          r_sticky    <= w_stickyNext;
          r_sampleCnt <= r_sampleCnt + 1'b1;
        end
      end
    end
  end

  assign zcr_count = r_zcrCount;
  assign zcr_valid = r_zcrValid;
  assign zcr_sat   = r_zcrSat;

endmodule

// File: tb/tb_zcr_windowed.sv
// tb_zcr_windowed: directed bench for zcr_windowed (WINDOW_SIZE=8, CNT_WIDTH=3).
// A reference model recomputes each window's crossings from the list of
// sample polarities and is compared against the DUT every cycle; literal
// expectations at the end of each scenario pin the model as well.
module tb_zcr_windowed;

  localparam int DW = 16;
  localparam int WS = 8;
  localparam int CW = 3;
  localparam int MAXCNT = (1 << CW) - 1;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 enable = 1'b1;
  logic                 clear = 1'b0;
  logic signed [DW-1:0] data_in = '0;
  logic                 data_valid = 1'b0;
  logic        [DW-2:0] thresh = '0;
  logic        [CW-1:0] zcr_count;
  logic                 zcr_valid;
  logic                 zcr_sat;

  int compared = 0;
  int mismatched = 0;

  // Reference model state: polarities of the current window and the last
  // known polarity when the window began (0 = unknown).
  int qSign[$];
  int startSign = 0;
  int expCount = 0;
  int expSat = 0;
  int expValid = 0;
  bit modelCheckOn = 1'b0;

  zcr_windowed #(
    .DATA_WIDTH (DW),
    .WINDOW_SIZE(WS),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .clear     (clear),
    .data_in   (data_in),
    .data_valid(data_valid),
    .thresh    (thresh),
    .zcr_count (zcr_count),
    .zcr_valid (zcr_valid),
    .zcr_sat   (zcr_sat)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // Reference model: classify each accepted sample, and at the end of a
  // window count polarity flips across the whole sequence in one pass.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      qSign.delete();
      startSign = 0;
      expCount = 0;
      expSat = 0;
      expValid = 0;
    end else begin
      expValid = 0;
      if (clear) begin
        qSign.delete();
        startSign = 0;
      end else if (enable && data_valid) begin
        int d;
        int t;
        d = int'(data_in);
        t = int'(thresh);
        if (d > t) qSign.push_back(1);
        else if (d < -t) qSign.push_back(-1);
        else qSign.push_back(0);
        if (qSign.size() == WS) begin
          int c;
          int prev;
          c = 0;
          prev = startSign;
          foreach (qSign[k]) begin
            if (qSign[k] != 0) begin
              if (prev != 0 && prev != qSign[k]) c++;
              prev = qSign[k];
            end
          end
          startSign = prev;
          expCount = (c > MAXCNT) ? MAXCNT : c;
          expSat = (c > MAXCNT) ? 1 : 0;
          expValid = 1;
          qSign.delete();
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (modelCheckOn) begin
      compared++;
      if (int'(zcr_valid) != expValid || int'(zcr_count) != expCount ||
          int'(zcr_sat) != expSat) begin
        mismatched++;
        $display("[TB] FAIL model t=%0t: got valid=%0d count=%0d sat=%0d, need valid=%0d count=%0d sat=%0d",
                 $time, zcr_valid, zcr_count, zcr_sat, expValid, expCount, expSat);
      end
    end
  end

  // Drive one cycle of inputs; the edge after the call consumes them.
  task automatic applyStimulus(input int d, input bit dv, input bit en, input bit clr);
    data_in = DW'(d);
    data_valid = dv;
    enable = en;
    clear = clr;
    @(posedge clk);
    #1;
    data_valid = 1'b0;
    clear = 1'b0;
    enable = 1'b1;
  endtask

  // Literal check of the outputs, either at the next falling edge or right now.
  task automatic checkOutput(input string name, input int cnt, input int sat,
                             input int vld, input bit atNegedge);
    if (atNegedge) @(negedge clk);
    compared++;
    if (int'(zcr_count) != cnt || int'(zcr_sat) != sat || int'(zcr_valid) != vld) begin
      mismatched++;
      $display("[TB] FAIL %s: got count=%0d sat=%0d valid=%0d, need count=%0d sat=%0d valid=%0d",
               name, zcr_count, zcr_sat, zcr_valid, cnt, sat, vld);
    end
  endtask

  // Eight back-to-back samples alternating in sign, starting with firstVal.
  task automatic alternate8(input int firstVal);
    for (int i = 0; i < 8; i++) begin
      applyStimulus((i % 2 == 0) ? firstVal : -firstVal, 1'b1, 1'b1, 1'b0);
    end
  endtask

  int seqA[8] = '{100, 20, -20, -40, -100, -30, 30, 100};
  int seqB[8] = '{100, -100, 101, -101, 100, -100, -101, 101};
  int seqC[8] = '{-32768, 32767, -32767, 0, 0, 0, 0, -32768};

  // Directed scenario list.
  initial begin
    modelCheckOn = 1'b1;
    #22;
    checkOutput("reset_state", 0, 0, 0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Plain alternation from an unknown tracker: seven flips.
    thresh = '0;
    alternate8(100);
    checkOutput("alt_first_window", 7, 0, 1, 1'b1);
    checkOutput("alt_valid_drops", 7, 0, 0, 1'b1);

    // Continued alternation: eight flips saturate the 3-bit count.
    alternate8(100);
    checkOutput("alt_saturated", 7, 1, 1, 1'b1);

    // Restart the tracker, then a constant window has no flips.
    applyStimulus(0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) applyStimulus(100, 1'b1, 1'b1, 1'b0);
    checkOutput("constant_window", 0, 0, 1, 1'b1);

    // Hysteresis: dead samples never move the tracker.
    thresh = 15'd50;
    for (int i = 0; i < 8; i++) applyStimulus(seqA[i], 1'b1, 1'b1, 1'b0);
    checkOutput("thresh50", 2, 0, 1, 1'b1);
    thresh = '0;
    for (int i = 0; i < 8; i++) applyStimulus(seqA[i], 1'b1, 1'b1, 1'b0);
    checkOutput("thresh0", 2, 0, 1, 1'b1);

    // Samples equal to +/-thresh are dead; one step beyond is not.
    thresh = 15'd100;
    for (int i = 0; i < 8; i++) applyStimulus(seqB[i], 1'b1, 1'b1, 1'b0);
    checkOutput("thresh_edge", 2, 0, 1, 1'b1);

    // Widest threshold: only the most negative sample escapes the dead band.
    thresh = 15'h7FFF;
    for (int i = 0; i < 8; i++) applyStimulus(seqC[i], 1'b1, 1'b1, 1'b0);
    checkOutput("thresh_max", 1, 0, 1, 1'b1);

    // Gaps in data_valid and enable-low samples must not disturb the window.
    thresh = '0;
    applyStimulus(0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      applyStimulus((i % 2 == 0) ? 100 : -100, 1'b1, 1'b1, 1'b0);
      applyStimulus(0, 1'b0, 1'b1, 1'b0);
      if (i == 2) begin
        applyStimulus(-100, 1'b1, 1'b0, 1'b0);
        applyStimulus(100, 1'b1, 1'b0, 1'b0);
        applyStimulus(-100, 1'b1, 1'b0, 1'b0);
      end
    end
    checkOutput("gaps_enable", 7, 0, 0, 1'b0);

    // Clear mid-window with a coincident sample: no pulse, result held.
    for (int i = 0; i < 5; i++) applyStimulus((i % 2 == 0) ? 100 : -100, 1'b1, 1'b1, 1'b0);
    applyStimulus(-100, 1'b1, 1'b1, 1'b1);
    checkOutput("clear_hold", 7, 0, 0, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1'b0, 1'b1, 1'b0);
    checkOutput("clear_no_pulse", 7, 0, 0, 1'b1);
    alternate8(-100);
    checkOutput("after_clear", 7, 0, 1, 1'b1);

    // Short asynchronous reset mid-window.
    applyStimulus(-100, 1'b1, 1'b1, 1'b0);
    applyStimulus(100, 1'b1, 1'b1, 1'b0);
    applyStimulus(-100, 1'b1, 1'b1, 1'b0);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("async_reset", 0, 0, 0, 1'b0);
    #2;
    reset = 1'b1;
    @(posedge clk);
    #1;
    alternate8(100);
    checkOutput("after_reset", 7, 0, 1, 1'b1);

    repeat (3) @(posedge clk);
    modelCheckOn = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
